// File: rtl/dance_pkg.sv
// Shared definitions for the gameplay scoring path: judgement codes,
// BCD sizing and the state encoding of the iterative BCD converter.
package dance_pkg;

    // Judgement codes emitted by the gameplay stage once per cycle
    localparam logic [1:0] UPD_NONE = 2'b00;
    localparam logic [1:0] UPD_HIT  = 2'b01;
    localparam logic [1:0] UPD_RSVD = 2'b10;
    localparam logic [1:0] UPD_MISS = 2'b11;

    // Five BCD digits cover every score up to 16 bits (65535)
    localparam int BCD_DIGITS = 5;
    localparam int BCD_W      = 20;

    // Converter phases: capture, one shift per bit, then publish
    typedef enum logic [1:0] {
        CV_IDLE,
        CV_LOAD,
        CV_SHIFT,
        CV_COMMIT
    } conv_state_t;

    // Double-dabble correction: any digit of 5 or more gets 3 added so the
    // following left shift carries correctly into the next decimal digit.
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] val);
        logic [BCD_W-1:0] res;
        res = val;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (res[d*4 +: 4] >= 4'd5) begin
                res[d*4 +: 4] = res[d*4 +: 4] + 4'd3;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative binary-to-BCD converter (shift-add-3), one input bit per cycle.
// A start request in IDLE (or while committing) leads to LOAD on the next
// edge, which captures 'bin'; W shifts follow, then COMMIT publishes 'bcd'
// and pulses 'done'.
module bin2bcd_iter
    import dance_pkg::*;
#(
    parameter int W = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     bin,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(W - 1);

    conv_state_t       state;
    conv_state_t       state_next;
    logic [W-1:0]      shreg;
    logic [BCD_W-1:0]  acc;
    logic [BCD_W-1:0]  acc_adj;
    logic [CNT_W-1:0]  cnt;

    assign acc_adj = bcd_add3(acc);

    // State register; reset aborts any conversion in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state sequencing and the busy/done status outputs
    always_comb begin
        state_next = state;
        busy       = (state != CV_IDLE);
        done       = 1'b0;
        case (state)
            CV_IDLE: begin
                if (start) begin
                    state_next = CV_LOAD;
                end
            end
            CV_LOAD: begin
                state_next = CV_SHIFT;
            end
            CV_SHIFT: begin
                if (cnt == LAST_SHIFT) begin
                    state_next = CV_COMMIT;
                end
            end
            CV_COMMIT: begin
                done       = 1'b1;
                state_next = start ? CV_LOAD : CV_IDLE;
            end
            default: begin
                state_next = CV_IDLE;
            end
        endcase
    end

    // Datapath: capture on LOAD, shift MSB-first into the BCD accumulator,
    // publish the finished digits on COMMIT
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            acc   <= '0;
            cnt   <= '0;
            bcd   <= '0;
        end else begin
            case (state)
                CV_LOAD: begin
                    shreg <= bin;
                    acc   <= '0;
                    cnt   <= '0;
                end
                CV_SHIFT: begin
                    acc   <= {acc_adj[BCD_W-2:0], shreg[W-1]};
                    shreg <= {shreg[W-2:0], 1'b0};
                    cnt   <= cnt + CNT_W'(1);
                end
                CV_COMMIT: begin
                    bcd <= acc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/score_streak_tracker.sv
// Score / streak / multiplier bookkeeping for the judgement stream, plus a
// lazily refreshed BCD image of the score for the HEX display stage.
module score_streak_tracker
    import dance_pkg::*;
#(
    parameter int SCORE_W     = 16,
    parameter int STREAK_W    = 8,
    parameter int BASE_POINTS = 1,
    parameter int MULT_STEP   = 5,
    parameter int MAX_MULT    = 4
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic [1:0]          update_sel,
    output logic [SCORE_W-1:0]  score,
    output logic [STREAK_W-1:0] streak,
    output logic [STREAK_W-1:0] best_streak,
    output logic [2:0]          multiplier,
    output logic [BCD_W-1:0]    score_bcd,
    output logic                bcd_valid
);

    localparam int SUM_W = SCORE_W + 33;
    localparam logic [SCORE_W-1:0]  SCORE_MAX  = '1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = '1;

    logic                wipe;
    logic                is_hit;
    logic                is_miss;
    logic [31:0]         inc;
    logic [SUM_W-1:0]    sum_wide;
    logic [SCORE_W-1:0]  score_sat;
    logic                score_chg;
    logic [STREAK_W-1:0] streak_inc;
    logic [31:0]         mult_raw;
    logic [2:0]          mult_hit;
    logic                pending;
    logic                conv_start;
    logic                conv_busy;
    logic                conv_done;
    logic                conv_accept;

    // Reset and new-game clear both wipe everything and drop any update
    assign wipe    = rst | clear;
    assign is_hit  = !wipe && (update_sel == UPD_HIT);
    assign is_miss = !wipe && (update_sel == UPD_MISS);

    // Points for a hit use the multiplier held before this edge
    assign inc       = 32'(BASE_POINTS) * 32'(multiplier);
    assign sum_wide  = SUM_W'(score) + SUM_W'(inc);
    assign score_sat = (sum_wide > SUM_W'(SCORE_MAX)) ? SCORE_MAX : sum_wide[SCORE_W-1:0];
    assign score_chg = is_hit && (score_sat != score);

    // Multiplier follows the post-hit streak, capped at MAX_MULT
    assign streak_inc = (streak == STREAK_MAX) ? streak : streak + STREAK_W'(1);
    assign mult_raw   = (32'(streak_inc) / 32'(MULT_STEP)) + 32'd1;
    assign mult_hit   = (mult_raw > 32'(MAX_MULT)) ? 3'(MAX_MULT) : mult_raw[2:0];

    // Ask for a conversion whenever the displayed digits may be stale. The
    // converter accepts the request when idle or while committing, and the
    // following LOAD edge captures the score, so an accepted request
    // clears the pending flag.
    assign conv_start  = pending | score_chg;
    assign conv_accept = conv_start && (!conv_busy || conv_done);

    // Counters: score, streak, best streak and multiplier
    always_ff @(posedge clk) begin
        if (wipe) begin
            score       <= '0;
            streak      <= '0;
            best_streak <= '0;
            multiplier  <= 3'd1;
        end else if (is_hit) begin
            score      <= score_sat;
            streak     <= streak_inc;
            multiplier <= mult_hit;
            if (streak_inc > best_streak) begin
                best_streak <= streak_inc;
            end
        end else if (is_miss) begin
            streak     <= '0;
            multiplier <= 3'd1;
        end
    end

    // Staleness tracking: valid drops with any score change and returns
    // only when a conversion commits with no newer change outstanding
    always_ff @(posedge clk) begin
        if (wipe) begin
            pending   <= 1'b0;
            bcd_valid <= 1'b1;
        end else begin
            if (conv_accept) begin
                pending <= 1'b0;
            end else if (score_chg) begin
                pending <= 1'b1;
            end
            if (score_chg) begin
                bcd_valid <= 1'b0;
            end else if (conv_done && !pending) begin
                bcd_valid <= 1'b1;
            end
        end
    end

    bin2bcd_iter #(
        .W(SCORE_W)
    ) u_bcd (
        .clk   (clk),
        .rst   (wipe),
        .start (conv_start),
        .bin   (score),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (score_bcd)
    );

endmodule

// File: tb/tb_score_streak_tracker.sv
// Self-checking bench for score_streak_tracker: a directed vector table for
// the counter behaviour plus hand-written sequences for BCD latency,
// saturation on a narrow instance and clear during conversion.
module tb_score_streak_tracker;
    import dance_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        clear_big;
    logic [1:0]  upd_big;
    logic [15:0] score_big;
    logic [7:0]  streak_big;
    logic [7:0]  best_big;
    logic [2:0]  mult_big;
    logic [19:0] bcd_big;
    logic        valid_big;

    logic        clear_small;
    logic [1:0]  upd_small;
    logic [7:0]  score_small;
    logic [2:0]  streak_small;
    logic [2:0]  best_small;
    logic [2:0]  mult_small;
    logic [19:0] bcd_small;
    logic        valid_small;

    score_streak_tracker dut_big (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear_big),
        .update_sel  (upd_big),
        .score       (score_big),
        .streak      (streak_big),
        .best_streak (best_big),
        .multiplier  (mult_big),
        .score_bcd   (bcd_big),
        .bcd_valid   (valid_big)
    );

    score_streak_tracker #(
        .SCORE_W  (8),
        .STREAK_W (3)
    ) dut_small (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear_small),
        .update_sel  (upd_small),
        .score       (score_small),
        .streak      (streak_small),
        .best_streak (best_small),
        .multiplier  (mult_small),
        .score_bcd   (bcd_small),
        .bcd_valid   (valid_small)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] upd;
        logic       clr;
        int         score;
        int         streak;
        int         best;
        int         mult;
        int         valid;
    } vec_t;

    vec_t vecs[$];

    // Hand-computed scores and multipliers after each of 20 hits from zero
    int hit_scores[20] = '{1, 2, 3, 4, 5, 7, 9, 11, 13, 15,
                           18, 21, 24, 27, 30, 34, 38, 42, 46, 50};
    int hit_mults[20]  = '{1, 1, 1, 1, 2, 2, 2, 2, 2, 3,
                           3, 3, 3, 3, 4, 4, 4, 4, 4, 4};

    function automatic void addVec(input logic [1:0] u, input logic c, input int s,
                                   input int st, input int b, input int m, input int v);
        vec_t r;
        r.upd = u; r.clr = c; r.score = s; r.streak = st;
        r.best = b; r.mult = m; r.valid = v;
        vecs.push_back(r);
    endfunction

    task automatic applyStimulus(input logic [1:0] u, input logic c);
        upd_big   = u;
        clear_big = c;
        @(posedge clk);
        #1;
        upd_big   = UPD_NONE;
        clear_big = 1'b0;
    endtask

    task automatic applyStimulusSmall(input logic [1:0] u, input logic c);
        upd_small   = u;
        clear_small = c;
        @(posedge clk);
        #1;
        upd_small   = UPD_NONE;
        clear_small = 1'b0;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        upd_big = UPD_NONE;   clear_big = 1'b0;
        upd_small = UPD_NONE; clear_small = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("reset score",  score_big, 0);
        checkOutput("reset streak", streak_big, 0);
        checkOutput("reset best",   best_big, 0);
        checkOutput("reset mult",   mult_big, 1);
        checkOutput("reset bcd",    bcd_big, 0);
        checkOutput("reset valid",  valid_big, 1);
        checkOutput("reset small score", score_small, 0);
        checkOutput("reset small valid", valid_small, 1);

        // Run-up of 5 hits, then a 6th
        addVec(UPD_HIT, 1'b0, 1, 1, 1, 1, 0);
        addVec(UPD_HIT, 1'b0, 2, 2, 2, 1, 0);
        addVec(UPD_HIT, 1'b0, 3, 3, 3, 1, 0);
        addVec(UPD_HIT, 1'b0, 4, 4, 4, 1, 0);
        addVec(UPD_HIT, 1'b0, 5, 5, 5, 2, 0);
        addVec(UPD_HIT, 1'b0, 7, 6, 6, 2, 0);
        // Miss, idle, then one more hit
        addVec(UPD_MISS, 1'b0, 7, 0, 6, 1, 0);
        addVec(UPD_NONE, 1'b0, 7, 0, 6, 1, 0);
        addVec(UPD_HIT,  1'b0, 8, 1, 6, 1, 0);
        // Clear (with a dropped hit), then 20 hits with reserved codes between
        addVec(UPD_HIT, 1'b1, 0, 0, 0, 1, 1);
        for (int k = 0; k < 20; k++) begin
            addVec(UPD_HIT,  1'b0, hit_scores[k], k + 1, k + 1, hit_mults[k], 0);
            addVec(UPD_RSVD, 1'b0, hit_scores[k], k + 1, k + 1, hit_mults[k], 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].upd, vecs[i].clr);
            checkOutput($sformatf("vec%0d score", i),  score_big,  vecs[i].score);
            checkOutput($sformatf("vec%0d streak", i), streak_big, vecs[i].streak);
            checkOutput($sformatf("vec%0d best", i),   best_big,   vecs[i].best);
            checkOutput($sformatf("vec%0d mult", i),   mult_big,   vecs[i].mult);
            checkOutput($sformatf("vec%0d valid", i),  valid_big,  vecs[i].valid);
        end

        // BCD latency: one hit from zero at edge N, digits appear at N+18
        applyStimulus(UPD_NONE, 1'b1);
        checkOutput("lat cleared valid", valid_big, 1);
        applyStimulus(UPD_HIT, 1'b0);
        checkOutput("lat score", score_big, 1);
        checkOutput("lat valid at N", valid_big, 0);
        for (int k = 1; k <= 17; k++) begin
            applyStimulus(UPD_NONE, 1'b0);
            checkOutput($sformatf("lat valid N+%0d", k), valid_big, 0);
            checkOutput($sformatf("lat bcd N+%0d", k), bcd_big, 0);
        end
        applyStimulus(UPD_NONE, 1'b0);
        checkOutput("lat valid N+18", valid_big, 1);
        checkOutput("lat bcd N+18", bcd_big, 'h00001);

        // 1234 single points, multiplier pinned to 1 by a miss before each hit
        applyStimulus(UPD_NONE, 1'b1);
        for (int k = 0; k < 1234; k++) begin
            applyStimulus(UPD_MISS, 1'b0);
            applyStimulus(UPD_HIT, 1'b0);
        end
        checkOutput("1234 score", score_big, 1234);
        for (int k = 0; k < 60 && valid_big !== 1'b1; k++) begin
            applyStimulus(UPD_NONE, 1'b0);
        end
        checkOutput("1234 valid", valid_big, 1);
        checkOutput("1234 bcd", bcd_big, 'h01234);

        // Clear five cycles into a conversion, with a hit that must be dropped
        applyStimulus(UPD_HIT, 1'b0);
        checkOutput("abort pre score", score_big, 1235);
        repeat (4) applyStimulus(UPD_NONE, 1'b0);
        applyStimulus(UPD_HIT, 1'b1);
        checkOutput("abort score",  score_big, 0);
        checkOutput("abort streak", streak_big, 0);
        checkOutput("abort best",   best_big, 0);
        checkOutput("abort mult",   mult_big, 1);
        checkOutput("abort bcd",    bcd_big, 0);
        checkOutput("abort valid",  valid_big, 1);
        repeat (20) applyStimulus(UPD_NONE, 1'b0);
        checkOutput("abort later bcd",   bcd_big, 0);
        checkOutput("abort later valid", valid_big, 1);

        // Saturation on the 8-bit score / 3-bit streak instance
        for (int k = 0; k < 300; k++) begin
            applyStimulusSmall(UPD_HIT, 1'b0);
        end
        checkOutput("sat score",  score_small, 255);
        checkOutput("sat streak", streak_small, 7);
        checkOutput("sat best",   best_small, 7);
        checkOutput("sat mult",   mult_small, 2);
        for (int k = 0; k < 40 && valid_small !== 1'b1; k++) begin
            applyStimulusSmall(UPD_NONE, 1'b0);
        end
        checkOutput("sat valid", valid_small, 1);
        checkOutput("sat bcd", bcd_small, 'h00255);
        applyStimulusSmall(UPD_HIT, 1'b0);
        checkOutput("sat hold score", score_small, 255);
        checkOutput("sat hold valid", valid_small, 1);
        checkOutput("sat hold bcd", bcd_small, 'h00255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
